// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch-stage program counter with stall, branch buffering and flush
module pc_ctrl #(
   parameter int unsigned     PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter int unsigned     STEP      = 4,
   parameter bit              ALIGN     = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_flag,
   input  logic [PC_W-1:0] branch_target,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_pc,
   output logic [PC_W-1:0] pc,
   output logic            ce,
   output logic            pending
);

   typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pend_target_q, pend_target_d;
   logic            pending_q, pending_d;

   function automatic logic [PC_W-1:0] align_f(input logic [PC_W-1:0] x);
      return ALIGN ? {x[PC_W-1:2], 2'b00} : x;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_OFF;
         pc_q          <= RESET_VEC;
         pend_target_q <= '0;
         pending_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         pending_q     <= pending_d;
      end
   end

   // OFF lasts exactly one edge so the first fetch is RESET_VEC with ce high.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      pending_d     = pending_q;
      if (state_q == ST_OFF) begin
         state_d = ST_RUN;
      end else if (flush) begin
         pc_d      = align_f(flush_pc);
         pending_d = 1'b0;
      end else if (stall) begin
         if (branch_flag) begin
            pending_d     = 1'b1;
            pend_target_d = align_f(branch_target);
         end
      end else if (branch_flag) begin
         pc_d      = align_f(branch_target);
         pending_d = 1'b0;
      end else if (pending_q) begin
         pc_d      = pend_target_q;
         pending_d = 1'b0;
      end else begin
         pc_d = pc_q + STEP_V;
      end
   end

   assign pc      = pc_q;
   assign ce      = (state_q == ST_RUN);
   assign pending = pending_q;

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Parametrised program-counter unit for the MIPS fetch stage. It generates the fetch address and instruction-memory chip enable. It supports pipeline stall, branch/jump redirect, and exception/ERET flush. A branch that resolves while fetch is stalled is buffered, then applied when the stall releases. It sits between the control/hazard logic and the instruction ROM address port.

## Interface
Parameters:
- `PC_W`, 32, width of the program counter and all target buses.
- `RESET_VEC`, 32'h00000000, first fetch address after reset.
- `STEP`, 4, sequential increment in bytes.
- `ALIGN`, 1, when 1 the low two bits of every loaded target are forced to 0.

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  hold the PC; from hazard/stall control.
- `branch_flag`  in  1  redirect request from the branch/jump unit.
- `branch_target`  in  PC_W  redirect address, sampled when `branch_flag`=1.
- `flush`  in  1  exception entry or ERET redirect; highest priority.
- `flush_pc`  in  PC_W  redirect address for `flush`.
- `pc`  out  PC_W  current fetch address, registered.
- `ce`  out  1  instruction-memory chip enable, registered.
- `pending`  out  1  a buffered branch is waiting for the stall to release.

## Operation
- Two states: OFF (`ce`=0) and RUN (`ce`=1).
- While `rst`=0, asynchronously: state OFF, `ce`=0, `pc`=RESET_VEC, `pending`=0, internal `pend_target`=0.
- OFF to RUN on the first rising edge with `rst`=1.
  - On that edge `pc` is unchanged and all other inputs are ignored.
  - The first fetch is therefore at RESET_VEC with `ce`=1.
- In RUN, on each edge, the first matching rule applies:
  1. `flush`=1: `pc`<=align(`flush_pc`), `pending`<=0. This applies even if `stall`=1.
  2. `stall`=1: `pc` holds.
     - If `branch_flag`=1: `pending`<=1 and `pend_target`<=align(`branch_target`).
     - A later branch while still stalled overwrites the buffered target.
  3. `branch_flag`=1: `pc`<=align(`branch_target`), `pending`<=0. A live branch beats a buffered one.
  4. `pending`=1: `pc`<=`pend_target`, `pending`<=0.
  5. Otherwise: `pc`<=`pc`+STEP.
- Arithmetic is modulo 2^PC_W; the increment wraps with no flag.
- align(x) = {x[PC_W-1:2],2'b00} when ALIGN=1, else x.
- RUN returns to OFF only through reset.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Redirect latency is one edge. A `branch_flag` or `flush` sampled at edge N makes `pc` show the target after edge N.
- A buffered branch is applied on the first edge with `stall`=0 and `flush`=0. `pending` drops on that same edge.
- Reset asserted mid-operation:
  - `ce`, `pc` and `pending` take their reset values immediately, without waiting for a clock.
  - After release, the one-cycle OFF step repeats.
- `stall` with no branch holds `pc` indefinitely, and `ce` stays 1.

## Test plan
- Reset and start. Hold `rst`=0 for 3 cycles, then release.
  - Required: `ce`=0 and `pc`=0 during reset.
  - First edge after release: `ce`=1, `pc`=0.
  - Next edges: `pc`=4, then 8, then 12.
- Branch redirect. At `pc`=8, pulse `branch_flag` with `branch_target`=0x40.
  - Required: `pc`=0x40 on the next edge, then 0x44.
  - With ALIGN=1, target 0x43 gives `pc`=0x40.
- Buffered branch.
  - Stimulus: `stall`=1 for 3 edges at `pc`=0x10. Pulse `branch_flag`/0x80 on the first stalled edge, then 0x90 on the second.
  - Required: `pc` holds 0x10 and `pending`=1 while stalled.
  - First unstalled edge: `pc`=0x90, `pending`=0.
- Flush priority. Apply `stall`=1, `branch_flag`=1 (0x20) and `flush`=1 (`flush_pc`=0x180) together.
  - Required: `pc`=0x180, `pending`=0.
- Wrap-around. With PC_W=8 and RESET_VEC=8'hF8, run 3 edges after start.
  - Required: `pc` goes F8, then FC, then 00.
- Asynchronous reset mid-run. Pull `rst` low between clock edges while `pending`=1 and `pc`=0x44.
  - Required: `pc`=RESET_VEC, `ce`=0 and `pending`=0 before the next edge.
